// File: rtl/fp_result_buffer.sv
// Result FIFO behind the non-stallable FP multiply pipeline, with credit-based issue throttling.
// Optional sticky fflags accumulator built when FP_RESULT_BUFFER_FFLAGS_EN is defined.
module fp_result_buffer #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic        res_valid,
  input  logic [31:0] res_data,
  input  logic        res_nv,
  input  logic        res_of,
  input  logic        res_uf,
  input  logic        res_nx,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_flags,
  output logic [4:0]  fflags,
  input  logic        fflags_clr,
  output logic        overrun
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic [35:0]      r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] r_inflight;
  logic             r_overrun;

  logic             w_pop;
  logic             w_push;
  logic             w_issue_fire;
  logic [CNT_W:0]   w_credit_used;
  logic [CNT_W-1:0] w_count_nxt;
  logic [CNT_W-1:0] w_inflight_nxt;
  logic [35:0]      w_head;

  assign w_head        = r_mem[r_rd_ptr];
  assign out_valid     = (r_count != {CNT_W{1'b0}});
  assign out_data      = w_head[35:4];
  assign out_flags     = {w_head[3], 1'b0, w_head[2:0]};
  assign overrun       = r_overrun;
  assign w_pop         = out_valid & out_ready;
  // A pop in the same cycle frees the slot the incoming result needs.
  assign w_push        = res_valid & ((r_count < DEPTH_C) | w_pop);
  assign w_credit_used = {1'b0, r_count} + {1'b0, r_inflight};
  assign issue_ready   = ~rst & (w_credit_used < {1'b0, DEPTH_C});
  assign w_issue_fire  = issue_valid & issue_ready;

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // A stray result with nothing in flight must not wrap the credit counter.
  always_comb begin
    w_inflight_nxt = r_inflight;
    if (w_issue_fire && !res_valid) begin
      w_inflight_nxt = r_inflight + CNT_W'(1);
    end else if (!w_issue_fire && res_valid && (r_inflight != {CNT_W{1'b0}})) begin
      w_inflight_nxt = r_inflight - CNT_W'(1);
    end else begin
      w_inflight_nxt = r_inflight;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_inflight <= {CNT_W{1'b0}};
      r_overrun  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= 36'h0;
      end
    end else begin
      r_count    <= w_count_nxt;
      r_inflight <= w_inflight_nxt;
      if (w_push) begin
        r_mem[r_wr_ptr] <= {res_data, res_nv, res_of, res_uf, res_nx};
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (res_valid && !w_push) begin
        r_overrun <= 1'b1;
      end
    end
  end

`ifdef FP_RESULT_BUFFER_FFLAGS_EN
  logic [4:0] r_fflags;
  logic [4:0] w_fflags_nxt;

  // Flags accrue when a result leaves the buffer, not when it arrives.
  always_comb begin
    w_fflags_nxt = fflags_clr ? 5'b00000 : r_fflags;
    if (w_pop) begin
      w_fflags_nxt = w_fflags_nxt | out_flags;
    end else begin
      w_fflags_nxt = w_fflags_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_fflags <= 5'b00000;
    end else begin
      r_fflags <= w_fflags_nxt;
    end
  end

  assign fflags = r_fflags;
`else
  logic w_unused_fflags_clr;
  assign w_unused_fflags_clr = fflags_clr;
  assign fflags              = 5'b00000;
`endif

endmodule

// File: tb/tb_fp_result_buffer.sv
// Directed self-checking bench for fp_result_buffer (DEPTH=8); results are driven directly
// in place of the multiply pipeline.
module tb_fp_result_buffer;

`ifdef FP_RESULT_BUFFER_FFLAGS_EN
  localparam bit FF_EN = 1'b1;
`else
  localparam bit FF_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_ready;
  logic        res_valid;
  logic [31:0] res_data;
  logic        res_nv, res_of, res_uf, res_nx;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_flags;
  logic [4:0]  fflags;
  logic        fflags_clr;
  logic        overrun;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] data_tbl [8];
  logic [3:0]  flg_tbl  [8];

  fp_result_buffer #(.DEPTH(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_nv      (res_nv),
    .res_of      (res_of),
    .res_uf      (res_uf),
    .res_nx      (res_nx),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .fflags      (fflags),
    .fflags_clr  (fflags_clr),
    .overrun     (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_res(input logic [31:0] d, input logic [3:0] f);
    res_valid = 1'b1;
    res_data  = d;
    {res_nv, res_of, res_uf, res_nx} = f;
  endtask

  function automatic logic [4:0] ext_flags(input logic [3:0] f);
    return {f[3], 1'b0, f[2:0]};
  endfunction

  initial begin
    for (int i = 0; i < 8; i++) data_tbl[i] = 32'hA000_0000 + 32'(i);
    flg_tbl[0] = 4'b1000; flg_tbl[1] = 4'b0001; flg_tbl[2] = 4'b0100; flg_tbl[3] = 4'b0010;
    flg_tbl[4] = 4'b0000; flg_tbl[5] = 4'b0000; flg_tbl[6] = 4'b0000; flg_tbl[7] = 4'b1111;

    rst = 1'b1; issue_valid = 1'b0; res_valid = 1'b0; res_data = 32'h0;
    {res_nv, res_of, res_uf, res_nx} = 4'b0000;
    out_ready = 1'b0; fflags_clr = 1'b0;
    repeat (2) tick();
    check_eq("rst_issue_ready", 32'(issue_ready), 32'd0);
    check_eq("rst_out_valid",   32'(out_valid),   32'd0);
    check_eq("rst_out_data",    out_data,         32'h0);
    check_eq("rst_out_flags",   32'(out_flags),   32'd0);
    check_eq("rst_fflags",      32'(fflags),      32'd0);
    check_eq("rst_overrun",     32'(overrun),     32'd0);
    rst = 1'b0;
    #1;
    check_eq("release_issue_ready", 32'(issue_ready), 32'd1);

    // Fill credits with out_ready low.
    issue_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("fill_ready_%0d", i), 32'(issue_ready), 32'd1);
      tick();
    end
    check_eq("credits_exhausted", 32'(issue_ready), 32'd0);
    tick();
    issue_valid = 1'b0;
    check_eq("blocked_issue_no_change", 32'(issue_ready), 32'd0);

    for (int i = 0; i < 8; i++) begin
      drive_res(data_tbl[i], flg_tbl[i]);
      if (i == 0) check_eq("empty_no_bypass", 32'(out_valid), 32'd0);
      tick();
      if (i == 0) begin
        check_eq("latency_valid", 32'(out_valid), 32'd1);
        check_eq("latency_data",  out_data,       data_tbl[0]);
      end
    end
    res_valid = 1'b0;
    check_eq("full_head_data",  out_data,         data_tbl[0]);
    check_eq("full_head_flags", 32'(out_flags),   32'(ext_flags(flg_tbl[0])));
    check_eq("full_no_overrun", 32'(overrun),     32'd0);
    check_eq("full_issue_ready", 32'(issue_ready), 32'd0);
    check_eq("no_accrue_at_push", 32'(fflags),    32'd0);

    // Result into a full FIFO with no pop is dropped.
    drive_res(32'hDEAD_BEEF, 4'b0000);
    tick();
    res_valid = 1'b0;
    check_eq("overrun_set",      32'(overrun),     32'd1);
    check_eq("overrun_head",     out_data,         data_tbl[0]);
    check_eq("overrun_ready",    32'(issue_ready), 32'd0);
    tick();
    check_eq("stall_hold_data",  out_data,         data_tbl[0]);
    check_eq("stall_hold_flags", 32'(out_flags),   32'(ext_flags(flg_tbl[0])));

    // Push and pop together at full.
    out_ready = 1'b1;
    drive_res(32'h3F80_0000, 4'b0000);
    tick();
    out_ready = 1'b0; res_valid = 1'b0;
    check_eq("pushpop_full_head",  out_data,         data_tbl[1]);
    check_eq("pushpop_full_count", 32'(issue_ready), 32'd0);
    check_eq("fflags_pop0", 32'(fflags), FF_EN ? 32'h10 : 32'h0);

    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("fflags_pop1",     32'(fflags),      FF_EN ? 32'h11 : 32'h0);
    check_eq("ready_after_pop", 32'(issue_ready), 32'd1);
    check_eq("head_entry2",     out_data,         data_tbl[2]);

    out_ready = 1'b1; fflags_clr = 1'b1;
    tick();
    out_ready = 1'b0; fflags_clr = 1'b0;
    check_eq("fflags_clr_pop", 32'(fflags), FF_EN ? 32'h04 : 32'h0);

    out_ready = 1'b1;
    repeat (4) tick();
    out_ready = 1'b0;
    check_eq("head_entry7_data",  out_data,       data_tbl[7]);
    check_eq("head_entry7_flags", 32'(out_flags), 32'h17);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("fflags_pop7",    32'(fflags),    FF_EN ? 32'h17 : 32'h0);
    check_eq("tail_value",     out_data,       32'h3F80_0000);
    check_eq("tail_flags",     32'(out_flags), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("drained",        32'(out_valid), 32'd0);
    check_eq("overrun_sticky", 32'(overrun),   32'd1);

    // Push and pop together at count=1.
    drive_res(32'h1111_1111, 4'b0001);
    tick();
    check_eq("one_entry", out_data, 32'h1111_1111);
    drive_res(32'h2222_2222, 4'b0000);
    out_ready = 1'b1;
    tick();
    res_valid = 1'b0; out_ready = 1'b0;
    check_eq("pushpop_one_valid", 32'(out_valid), 32'd1);
    check_eq("pushpop_one_data",  out_data,       32'h2222_2222);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check_eq("pushpop_one_drain", 32'(out_valid), 32'd0);

    // Reset with 3 buffered and 2 in flight.
    issue_valid = 1'b1;
    repeat (5) tick();
    issue_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_res(data_tbl[i], flg_tbl[i]);
      tick();
    end
    res_valid = 1'b0;
    check_eq("pre_rst_valid", 32'(out_valid),   32'd1);
    check_eq("pre_rst_ready", 32'(issue_ready), 32'd1);
    rst = 1'b1;
    #1;
    check_eq("mid_rst_valid",   32'(out_valid),   32'd0);
    check_eq("mid_rst_ready",   32'(issue_ready), 32'd0);
    check_eq("mid_rst_data",    out_data,         32'h0);
    check_eq("mid_rst_flags",   32'(out_flags),   32'd0);
    check_eq("mid_rst_fflags",  32'(fflags),      32'd0);
    check_eq("mid_rst_overrun", 32'(overrun),     32'd0);
    tick();
    rst = 1'b0;
    #1;
    check_eq("post_rst_ready", 32'(issue_ready), 32'd1);
    tick();
    check_eq("post_rst_empty",  32'(out_valid),   32'd0);
    check_eq("post_rst_ready2", 32'(issue_ready), 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
